// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - sequences one div/mod request through the signed or unsigned divider IP
// Optional DIV_ZERO_BYPASS_EN: divisor 0 is answered locally without touching either IP.
module div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic        done,
    output logic [31:0] result,
    output logic        busy,
    output logic [31:0] s_dividend_data,
    output logic [31:0] s_divisor_data,
    output logic        s_dividend_valid,
    output logic        s_divisor_valid,
    input  logic        s_dividend_ready,
    input  logic        s_divisor_ready,
    input  logic        s_dout_valid,
    input  logic [63:0] s_dout_data,
    output logic [31:0] u_dividend_data,
    output logic [31:0] u_divisor_data,
    output logic        u_dividend_valid,
    output logic        u_divisor_valid,
    input  logic        u_dividend_ready,
    input  logic        u_divisor_ready,
    input  logic        u_dout_valid,
    input  logic [63:0] u_dout_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic        is_div_q, is_div_d;
    logic        use_s_q, use_s_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic        dvd_vld_q, dvd_vld_d;
    logic        dvs_vld_q, dvs_vld_d;
    logic        dvd_acc_q, dvd_acc_d;
    logic        dvs_acc_q, dvs_acc_d;
    logic [31:0] result_q, result_d;

    logic        req_onehot;
    logic        sel_dvd_ready;
    logic        sel_dvs_ready;
    logic        sel_dout_valid;
    logic [63:0] sel_dout_data;
    logic        dvd_fire;
    logic        dvs_fire;
    logic        both_acc;

    assign req_onehot     = (req_op != 4'd0) && ((req_op & (req_op - 4'd1)) == 4'd0);
    assign sel_dvd_ready  = use_s_q ? s_dividend_ready : u_dividend_ready;
    assign sel_dvs_ready  = use_s_q ? s_divisor_ready  : u_divisor_ready;
    assign sel_dout_valid = use_s_q ? s_dout_valid     : u_dout_valid;
    assign sel_dout_data  = use_s_q ? s_dout_data      : u_dout_data;
    assign dvd_fire       = dvd_vld_q & sel_dvd_ready;
    assign dvs_fire       = dvs_vld_q & sel_dvs_ready;
    // A handshake completing this cycle already counts as accepted.
    assign both_acc       = (dvd_acc_q | dvd_fire) & (dvs_acc_q | dvs_fire);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            is_div_q  <= 1'b0;
            use_s_q   <= 1'b0;
            src1_q    <= 32'd0;
            src2_q    <= 32'd0;
            dvd_vld_q <= 1'b0;
            dvs_vld_q <= 1'b0;
            dvd_acc_q <= 1'b0;
            dvs_acc_q <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            use_s_q   <= use_s_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            dvd_vld_q <= dvd_vld_d;
            dvs_vld_q <= dvs_vld_d;
            dvd_acc_q <= dvd_acc_d;
            dvs_acc_q <= dvs_acc_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        use_s_d   = use_s_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        dvd_vld_d = dvd_vld_q & ~dvd_fire;
        dvs_vld_d = dvs_vld_q & ~dvs_fire;
        dvd_acc_d = dvd_acc_q | dvd_fire;
        dvs_acc_d = dvs_acc_q | dvs_fire;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_onehot) begin
                    is_div_d  = req_op[0] | req_op[2];
                    use_s_d   = req_op[0] | req_op[1];
                    src1_d    = req_src1;
                    src2_d    = req_src2;
                    dvd_acc_d = 1'b0;
                    dvs_acc_d = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
                    if (req_src2 == 32'd0) begin
                        state_d  = ST_DONE;
                        result_d = (req_op[0] | req_op[2]) ? 32'hFFFF_FFFF : req_src1;
                    end else begin
                        state_d   = ST_ISSUE;
                        dvd_vld_d = 1'b1;
                        dvs_vld_d = 1'b1;
                    end
`else
                    state_d   = ST_ISSUE;
                    dvd_vld_d = 1'b1;
                    dvs_vld_d = 1'b1;
`endif
                end
            end
            ST_ISSUE: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (both_acc) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response arriving with the flush is itself the drained response.
                if (flush) begin
                    state_d = sel_dout_valid ? ST_IDLE : ST_DRAIN;
                end else if (sel_dout_valid) begin
                    state_d  = ST_DONE;
                    result_d = is_div_q ? sel_dout_data[63:32] : sel_dout_data[31:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (sel_dout_valid && both_acc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        done             = (state_q == ST_DONE) & ~flush;
        busy             = (state_q != ST_IDLE);
        result           = result_q;
        s_dividend_data  = src1_q;
        s_divisor_data   = src2_q;
        u_dividend_data  = src1_q;
        u_divisor_data   = src2_q;
        s_dividend_valid = dvd_vld_q & use_s_q;
        s_divisor_valid  = dvs_vld_q & use_s_q;
        u_dividend_valid = dvd_vld_q & ~use_s_q;
        u_divisor_valid  = dvs_vld_q & ~use_s_q;
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - scoreboard bench for div_ctrl with a behavioural divider IP responder
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_src1 = 32'd0;
    logic [31:0] req_src2 = 32'd0;
    logic        flush = 1'b0;
    logic        done;
    logic [31:0] result;
    logic        busy;
    logic [31:0] s_dividend_data, s_divisor_data, u_dividend_data, u_divisor_data;
    logic        s_dividend_valid, s_divisor_valid, u_dividend_valid, u_divisor_valid;
    logic        s_dividend_ready, s_divisor_ready, u_dividend_ready, u_divisor_ready;
    logic        s_dout_valid = 1'b0;
    logic        u_dout_valid = 1'b0;
    logic [63:0] s_dout_data = 64'd0;
    logic [63:0] u_dout_data = 64'd0;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
        .done(done), .result(result), .busy(busy),
        .s_dividend_data(s_dividend_data), .s_divisor_data(s_divisor_data),
        .s_dividend_valid(s_dividend_valid), .s_divisor_valid(s_divisor_valid),
        .s_dividend_ready(s_dividend_ready), .s_divisor_ready(s_divisor_ready),
        .s_dout_valid(s_dout_valid), .s_dout_data(s_dout_data),
        .u_dividend_data(u_dividend_data), .u_divisor_data(u_divisor_data),
        .u_dividend_valid(u_dividend_valid), .u_divisor_valid(u_divisor_valid),
        .u_dividend_ready(u_dividend_ready), .u_divisor_ready(u_divisor_ready),
        .u_dout_valid(u_dout_valid), .u_dout_data(u_dout_data)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int req_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int dout_cyc = -100;
    bit bypass_mode = 1'b0;
    bit s_seen = 1'b0;
    bit u_seen = 1'b0;
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pops one expected result.
    always @(negedge clk) begin
        if (s_dividend_valid || s_divisor_valid) s_seen = 1'b1;
        if (u_dividend_valid || u_divisor_valid) u_seen = 1'b1;
        if (!reset && done) begin
            done_cnt++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 result=%0h, expected done=0", result);
            end else begin
                check("result", result, exp_q.pop_front());
            end
            if (!bypass_mode) check("done_latency", cyc, dout_cyc + 1);
        end
    end

    // Divider IP responder shared by both IPs; delays set per test.
    int dvd_dly = 0, dvs_dly = 0, dout_dly = 2;
    int dvd_cnt = 0, dvs_cnt = 0, dcnt = 0;
    bit dvd_got = 0, dvs_got = 0, dvd_vl = 0, dvd_rl = 0, dvs_vl = 0, dvs_rl = 0;
    bit fired = 0, is_s = 0, dvd_v, dvs_v;
    logic dvd_rdy = 1'b0, dvs_rdy = 1'b0;
    logic [31:0] a_l = 32'd0, b_l = 32'd0, q, r;

    assign s_dividend_ready = dvd_rdy;
    assign u_dividend_ready = dvd_rdy;
    assign s_divisor_ready  = dvs_rdy;
    assign u_divisor_ready  = dvs_rdy;

    always @(posedge clk) begin
        #1;
        s_dout_valid = 1'b0;
        u_dout_valid = 1'b0;
        if (reset || !busy) begin
            dvd_cnt = 0; dvs_cnt = 0; dcnt = 0; fired = 0;
            dvd_got = 0; dvs_got = 0; dvd_vl = 0; dvd_rl = 0; dvs_vl = 0; dvs_rl = 0;
            dvd_rdy = (dvd_dly == 0);
            dvs_rdy = (dvs_dly == 0);
        end else begin
            if (dvd_vl && dvd_rl) dvd_got = 1;
            if (dvs_vl && dvs_rl) dvs_got = 1;
            dvd_v = s_dividend_valid | u_dividend_valid;
            dvs_v = s_divisor_valid | u_divisor_valid;
            if (s_dividend_valid || s_divisor_valid) is_s = 1;
            else if (u_dividend_valid || u_divisor_valid) is_s = 0;
            if (dvd_v) a_l = s_dividend_valid ? s_dividend_data : u_dividend_data;
            if (dvs_v) b_l = s_divisor_valid ? s_divisor_data : u_divisor_data;
            if (dvd_v && !dvd_got) dvd_cnt++;
            if (dvs_v && !dvs_got) dvs_cnt++;
            dvd_rdy = (dvd_dly == 0) || (dvd_v && !dvd_got && dvd_cnt >= dvd_dly);
            dvs_rdy = (dvs_dly == 0) || (dvs_v && !dvs_got && dvs_cnt >= dvs_dly);
            dvd_vl = dvd_v; dvd_rl = dvd_rdy;
            dvs_vl = dvs_v; dvs_rl = dvs_rdy;
            if (dvd_got && dvs_got && !fired) begin
                if (dcnt == dout_dly) begin
                    if (b_l == 32'd0) begin
                        q = 32'hFFFF_FFFF; r = a_l;
                    end else if (is_s) begin
                        q = $signed(a_l) / $signed(b_l); r = $signed(a_l) % $signed(b_l);
                    end else begin
                        q = a_l / b_l; r = a_l % b_l;
                    end
                    if (is_s) begin s_dout_data = {q, r}; s_dout_valid = 1'b1; end
                    else begin u_dout_data = {q, r}; u_dout_valid = 1'b1; end
                    dout_cyc = cyc;
                    fired = 1;
                end else if (dcnt == dout_dly - 1) begin
                    if (is_s) begin u_dout_data = 64'hDEAD_BEEF_0BAD_F00D; u_dout_valid = 1'b1; end
                    else begin s_dout_data = 64'hDEAD_BEEF_0BAD_F00D; s_dout_valid = 1'b1; end
                end
                dcnt++;
            end
        end
    end

    task automatic set_dly(input int dd, input int ds, input int dl);
        dvd_dly = dd; dvs_dly = ds; dout_dly = dl;
    endtask

    task automatic start_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b; req_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("done_seen", (done_cnt != d0), 1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int dd, input int ds, input int dl);
        set_dly(dd, ds, dl);
        exp_q.push_back(exp);
        start_req(op, a, b);
        wait_done(60);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int d0;
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 32'd0);
        check("rst_valids", {s_dividend_valid, s_divisor_valid, u_dividend_valid, u_divisor_valid}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Non-one-hot op codes are not requests.
        start_req(4'b0011, 32'd1, 32'd1);
        repeat (3) @(negedge clk);
        check("not_onehot_idle", busy, 0);
        @(posedge clk); #1;
        req_op = 4'b0000;
        repeat (2) @(negedge clk);
        check("zero_op_idle", busy, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;

        // divw 100 / -7, readies high, response 8 cycles after the request.
        set_dly(0, 0, 6);
        s_seen = 0; u_seen = 0;
        d0 = done_cnt;
        exp_q.push_back(32'hFFFF_FFF2);
        start_req(4'b0001, 32'd100, 32'hFFFF_FFF9);
        @(posedge clk); @(negedge clk);
        check("divw_valids_c1", {s_dividend_valid, s_divisor_valid}, 2'b11);
        check("divw_dividend_data", s_dividend_data, 32'd100);
        wait_done(60);
        check("divw_done_cycle", done_cyc, req_cyc + 9);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("divw_done_once", done_cnt, d0 + 1);
        check("divw_u_quiet", u_seen, 0);

        // modwu 0xFFFF_FFFF % 10 with a slow divisor channel.
        set_dly(0, 3, 3);
        exp_q.push_back(32'd5);
        start_req(4'b1000, 32'hFFFF_FFFF, 32'd10);
        @(posedge clk); @(negedge clk);
        check("modwu_valids_c1", {u_dividend_valid, u_divisor_valid}, 2'b11);
        @(posedge clk); @(negedge clk);
        check("modwu_valids_c2", {u_dividend_valid, u_divisor_valid}, 2'b01);
        repeat (2) @(negedge clk);
        check("modwu_valids_c4", {u_dividend_valid, u_divisor_valid, busy}, 3'b001);
        wait_done(60);
        @(posedge clk); #1;
        req_valid = 1'b0;

        // Back-to-back modw 7 % 3 then divw 7 / 3.
        set_dly(0, 0, 2);
        exp_q.push_back(32'd1);
        start_req(4'b0010, 32'd7, 32'd3);
        wait_done(60);
        @(posedge clk); #1;
        req_op = 4'b0001; req_cyc = cyc;
        exp_q.push_back(32'd2);
        @(negedge clk);
        check("b2b_idle_gap", busy, 0);
        @(posedge clk); @(negedge clk);
        check("b2b_second_accept", busy, 1);
        wait_done(60);
        @(posedge clk); #1;
        req_valid = 1'b0;

        // Flush in WAIT on divwu: drain to the response, no done, result kept.
        set_dly(0, 0, 5);
        d0 = done_cnt;
        start_req(4'b0100, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("wait_flush_busy", busy, 1);
        wait_idle(40);
        check("wait_flush_until_dout", cyc, dout_cyc + 1);
        check("wait_flush_no_done", done_cnt, d0);
        check("wait_flush_result", result, 32'd2);
        run_op(4'b0100, 32'd100, 32'd7, 32'd14, 0, 0, 3);

        // Flush in ISSUE with the divisor handshake still outstanding.
        set_dly(0, 3, 3);
        d0 = done_cnt;
        start_req(4'b0010, 32'd7, 32'd3);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        wait_idle(40);
        check("issue_flush_no_done", done_cnt, d0);
        check("issue_flush_result", result, 32'd14);

        // Flush during DONE suppresses done.
        set_dly(0, 0, 2);
        d0 = done_cnt;
        start_req(4'b0001, 32'd9, 32'd2);
        k = 0;
        while (cyc != dout_cyc + 1 && k < 30) begin
            @(posedge clk); #2;
            k++;
        end
        check("done_flush_reached", (cyc == dout_cyc + 1), 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("done_flush_idle", busy, 0);
        check("done_flush_no_done", done_cnt, d0);

        // Reset while in ISSUE abandons the transaction.
        set_dly(3, 3, 3);
        start_req(4'b0001, 32'd50, 32'd5);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("mid_rst_valids", {s_dividend_valid, s_divisor_valid, u_dividend_valid, u_divisor_valid}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;

        // Divide by zero.
`ifdef DIV_ZERO_BYPASS_EN
        bypass_mode = 1'b1;
        s_seen = 0; u_seen = 0;
        d0 = done_cnt;
        exp_q.push_back(32'hFFFF_FFFF);
        start_req(4'b0001, 32'd5, 32'd0);
        @(posedge clk); @(negedge clk); #1;
        check("bypass_div_done", done_cnt, d0 + 1);
        check("bypass_div_cycle", done_cyc, req_cyc + 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_q.push_back(32'd9);
        start_req(4'b0010, 32'd9, 32'd0);
        @(posedge clk); @(negedge clk); #1;
        check("bypass_mod_done", done_cnt, d0 + 2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("bypass_no_valid", {s_seen, u_seen}, 2'b00);
        bypass_mode = 1'b0;
`else
        set_dly(0, 0, 2);
        exp_q.push_back(32'hFFFF_FFFF);
        start_req(4'b0001, 32'd5, 32'd0);
        @(posedge clk); @(negedge clk);
        check("div0_to_ip", {s_dividend_valid, s_divisor_valid}, 2'b11);
        wait_done(60);
        @(posedge clk); #1;
        req_valid = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
